// File: rtl/regfile_multiport.sv
// Multi-port register file: combinational reads with optional same-cycle write bypass,
// hardwired zero register, and a clear engine that zeroes one register per cycle.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                clear_req,
  output logic                busy,
  output logic                clear_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NWR-1:0]  wr_acc;

  // A write is accepted outside CLEAR, except to r0 when it is hardwired.
  always_comb begin
    wr_acc = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_acc[j] = we[j] && (state_q != ST_CLEAR) &&
                  !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + (AW+1)'(1);
        end
      end
      ST_DONE: begin
        state_d = clear_req ? ST_CLEAR : ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Higher-numbered write ports are applied last so port 1 wins a collision.
  always_comb begin
    regs_d = regs_q;
    if (state_q == ST_CLEAR) begin
      regs_d[idx_q[AW-1:0]] = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_acc[j]) regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  // wr_acc already excludes CLEAR and hardwired r0, so forwarding inherits both rules.
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;
  always_comb begin
    rdata   = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr = raddr[i*AW +: AW];
      rd_val  = regs_q[rd_addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_acc[j] && (waddr[j*AW +: AW] == rd_addr)) rd_val = wdata[j*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr == '0)) rd_val = '0;
      rdata[i*XLEN +: XLEN] = rd_val;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: instance A has 3 read / 2 write ports with bypass, instance B is the
// default 2R/1W configuration without bypass.
module tb_regfile_multiport;

  logic        clock = 1'b0;
  logic        reset_n;

  logic [14:0] raddr_a;
  logic [95:0] rdata_a;
  logic [1:0]  we_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic        clr_a, busy_a, done_a;

  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [0:0]  we_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic        clr_b, busy_b, done_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_multiport #(.NRD(3), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .raddr(raddr_a), .rdata(rdata_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .clear_req(clr_a), .busy(busy_a), .clear_done(done_a)
  );

  regfile_multiport #(.NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .raddr(raddr_b), .rdata(rdata_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .clear_req(clr_b), .busy(busy_b), .clear_done(done_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rd_a(input int p);
    return rdata_a[p*32 +: 32];
  endfunction

  task automatic fill_a;
    for (int r = 1; r < 32; r++) begin
      we_a    = 2'b01;
      waddr_a = {5'd0, 5'(r)};
      wdata_a = {32'd0, 32'(r)};
      tick();
    end
    we_a = 2'b00;
  endtask

  // Runs 40 cycles from just after E0, returning busy-cycle and done-pulse counts.
  task automatic watch_a(output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      tick();
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, nz;

    vecs[0] = '{2'b11, 5'd3, 32'hABCDEFFF, 5'd5, 32'hFBCDE111, 5'd3, 5'd5, 5'd7,
                32'hABCDEFFF, 32'hFBCDE111, 32'h0};
    vecs[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd5, 5'd10,
                32'hABCDEFFF, 32'hFBCDE111, 32'h0};
    vecs[2] = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0};
    vecs[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd3,
                32'h0, 32'h0, 32'hABCDEFFF};
    vecs[4] = '{2'b11, 5'd9, 32'h11111111, 5'd9, 32'h22222222, 5'd9, 5'd9, 5'd5,
                32'h22222222, 32'h22222222, 32'hFBCDE111};
    vecs[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd3, 5'd0,
                32'h22222222, 32'hABCDEFFF, 32'h0};
    vecs[6] = '{2'b01, 5'd4, 32'h12345678, 5'd0, 32'h0, 5'd0, 5'd4, 5'd9,
                32'h0, 32'h12345678, 32'h22222222};
    vecs[7] = '{2'b11, 5'd7, 32'hAAAA0007, 5'd8, 32'hBBBB0008, 5'd7, 5'd8, 5'd4,
                32'hAAAA0007, 32'hBBBB0008, 32'h12345678};
    vecs[8] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd8, 5'd4,
                32'hAAAA0007, 32'hBBBB0008, 32'h12345678};

    reset_n = 1'b0;
    raddr_a = {5'd3, 5'd2, 5'd1}; we_a = '0; waddr_a = '0; wdata_a = '0; clr_a = 1'b0;
    raddr_b = {5'd4, 5'd3};       we_b = '0; waddr_b = '0; wdata_b = '0; clr_b = 1'b0;
    #3;
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_rdata_a", rdata_a[31:0] | rdata_a[63:32] | rdata_a[95:64], 32'd0);
    chk("reset_rdata_b", rdata_b[31:0] | rdata_b[63:32], 32'd0);
    #9 reset_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      we_a    = vecs[v].we;
      waddr_a = {vecs[v].wa1, vecs[v].wa0};
      wdata_a = {vecs[v].wd1, vecs[v].wd0};
      raddr_a = {vecs[v].ra2, vecs[v].ra1, vecs[v].ra0};
      #1;
      chk($sformatf("vec%0d_p0", v), rd_a(0), vecs[v].e0);
      chk($sformatf("vec%0d_p1", v), rd_a(1), vecs[v].e1);
      chk($sformatf("vec%0d_p2", v), rd_a(2), vecs[v].e2);
      tick();
    end
    we_a = '0;

    // No bypass: old value until the edge, hardwired r0 on the narrow instance too.
    we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h12345678; raddr_b = {5'd4, 5'd3};
    #1;
    chk("nobyp_same_cycle", rdata_b[63:32], 32'h0);
    tick();
    we_b = 1'b0;
    #1;
    chk("nobyp_next_cycle", rdata_b[63:32], 32'h12345678);
    we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hDEADBEEF;
    tick();
    we_b = 1'b0; raddr_b = {5'd0, 5'd0};
    #1;
    chk("nobyp_r0_p0", rdata_b[31:0], 32'h0);
    chk("nobyp_r0_p1", rdata_b[63:32], 32'h0);

    // Full clear with dropped writes and an ignored re-request.
    fill_a();
    raddr_a = {5'd17, 5'd31, 5'd1};
    #1;
    chk("fill_r1", rd_a(0), 32'd1);
    chk("fill_r31", rd_a(1), 32'd31);
    chk("fill_r17", rd_a(2), 32'd17);

    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int n = 0; n < 40; n++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; done_at = n; end
      we_a = 2'b00; clr_a = 1'b0;
      if (n == 3) begin
        we_a = 2'b01; waddr_a = {5'd0, 5'd31}; wdata_a = {32'd0, 32'h55};
      end
      if (n == 5) clr_a = 1'b1;
      if (n == 10) begin
        we_a = 2'b01; waddr_a = {5'd0, 5'd5}; wdata_a = {32'd0, 32'h55};
        raddr_a = {5'd20, 5'd5, 5'd2};
        #1;
        chk("mid_clear_cleared_r2", rd_a(0), 32'd0);
        chk("mid_clear_no_bypass_r5", rd_a(1), 32'd0);
        chk("mid_clear_old_r20", rd_a(2), 32'd20);
      end
      tick();
    end
    we_a = 2'b00; clr_a = 1'b0;
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clear_done_pulses", 32'(done_cnt), 32'd1);
    chk("clear_done_cycle", 32'(done_at), 32'd32);
    nz = 0;
    for (int r = 0; r < 32; r++) begin
      raddr_a = {5'd0, 5'd0, 5'(r)};
      #1;
      if (rd_a(0) != 32'd0) nz++;
    end
    chk("clear_all_zero", 32'(nz), 32'd0);
    raddr_a = {5'd0, 5'd31, 5'd5};
    #1;
    chk("clear_dropped_r5", rd_a(0), 32'd0);
    chk("clear_dropped_r31", rd_a(1), 32'd0);

    // Reset in the middle of a clear.
    tick();
    fill_a();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    repeat (10) tick();
    chk("busy_before_reset", 32'(busy_a), 32'd1);
    raddr_a = {5'd31, 5'd20, 5'd15};
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_busy", 32'(busy_a), 32'd0);
    chk("reset_mid_done", 32'(done_a), 32'd0);
    chk("reset_mid_r15", rd_a(0), 32'd0);
    chk("reset_mid_r20", rd_a(1), 32'd0);
    chk("reset_mid_r31", rd_a(2), 32'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    watch_a(busy_cnt, done_cnt);
    chk("post_reset_busy", 32'(busy_cnt), 32'd0);
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);

    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    watch_a(busy_cnt, done_cnt);
    chk("reclear_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("reclear_done_pulses", 32'(done_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port integer register file for the RISC-V single-cycle core. It is the successor to the fixed two-read/one-write `registerfile`. It adds configurable width, depth, read-port and write-port counts, an optional write-to-read bypass, a hardwired zero register, and a sequential clear engine. The clear engine zeroes the whole array on request without a full reset. The block sits between decode (read addresses) and writeback (write ports).

## Interface
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: number of registers; power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, 1–4.
- `NWR`, 1: number of write ports, 1–2.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes.
- `BYPASS`, 0: when 1, a same-cycle write is forwarded to the matching read ports.

Ports:
- `clock`, in, 1: rising-edge clock; the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `raddr`, in, NRD*AW: read addresses; port i occupies bits [i*AW +: AW].
- `rdata`, out, NRD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].
- `we`, in, NWR: per-port write enable.
- `waddr`, in, NWR*AW: write addresses.
- `wdata`, in, NWR*XLEN: write data.
- `clear_req`, in, 1: request an array clear; sampled on a clock edge.
- `busy`, out, 1: clear in progress.
- `clear_done`, out, 1: one-cycle pulse when a clear completes.

## Operation
- Reset (`reset_n` = 0, takes effect immediately):
  - all registers are 0;
  - the FSM is in IDLE with the clear index at 0;
  - `busy` = 0 and `clear_done` = 0;
  - `rdata` reflects zeros.
- Reads are combinational: `rdata[i] = reg[raddr[i]]`.
  - If `ZERO_REG` = 1 and `raddr[i]` = 0, the read returns 0.
- Writes occur on the rising edge when `we[j]` = 1, the FSM is not in CLEAR, and the write is not to register 0 with `ZERO_REG` = 1.
- Write collision (both ports write the same address): port 1 wins. Writes to distinct addresses both commit.
- Bypass (`BYPASS` = 1):
  - If an accepted write targets `raddr[i]` this cycle, `rdata[i]` returns that write's `wdata`.
  - When two writes match, port 1's data is forwarded.
  - There is no forwarding to register 0 when `ZERO_REG` = 1.
  - There is no forwarding while in CLEAR.
- Bypass off (`BYPASS` = 0): `rdata` shows the old value until after the edge.
- Clear FSM, states IDLE, CLEAR and DONE:
  - IDLE: `clear_req` = 1 → CLEAR, index ← 0.
  - CLEAR: at each edge, `reg[index]` ← 0 and index increments. When index = NREGS-1 is zeroed → DONE.
  - DONE: `clear_done` = 1. Writes are accepted. `clear_req` = 1 → CLEAR (restart); otherwise → IDLE.
  - `clear_req` in CLEAR is ignored; there is no queuing.
- During CLEAR:
  - all writes are silently dropped;
  - reads return current contents, so registers not yet cleared still show their old values.
- Width rules: the index is AW+1 bits so it never wraps inside CLEAR. Addresses ≥ NREGS cannot occur, because NREGS is a power of two.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 edge, or 0 with `BYPASS`.
- Clear sequence, with `clear_req` sampled at edge E0:
  - `busy` rises after E0 and falls after edge E_NREGS.
  - `reg[k]` is zeroed at edge E(k+1).
  - `clear_done` is high for exactly one cycle, from E_NREGS to E_NREGS+1.
  - Total `busy` duration is NREGS cycles.
- `busy` and `clear_done` are registered outputs, decoded from state; there is no combinational path from `clear_req`.
- Reset asserted mid-clear: the FSM returns to IDLE, all registers are 0, and no `clear_done` pulse is produced.
- A write and a `clear_req` in the same IDLE cycle: the write commits at E0, then is cleared later in the sequence.

## Test plan
- Write `0xABCDEFFF` to r3 and `0xFBCDE111` to r5. Next cycle, read r3/r5 → `0xABCDEFFF`/`0xFBCDE111`. Read the unwritten r7/r10 → 0/0.
- `ZERO_REG` = 1: write `0xDEADBEEF` to r0, then read r0 on all ports → 0. With `BYPASS` = 1, the same-cycle read of r0 → 0.
- `NWR` = 2, both ports write r9 (port 0 `0x11111111`, port 1 `0x22222222`) → r9 = `0x22222222`. With `BYPASS` = 1, the same-cycle `rdata` for r9 = `0x22222222`.
- `BYPASS` = 1, write `0x12345678` to r4 while `raddr[1]` = 4 → `rdata[1]` = `0x12345678` in the same cycle. `BYPASS` = 0 → old value (0) until the next cycle.
- Fill r1..r31 with their index values, then pulse `clear_req`:
  - `busy` is high for 32 cycles;
  - a write of `0x55` to r31 during CLEAR is dropped;
  - `clear_done` pulses once;
  - all reads then return 0;
  - a `clear_req` during `busy` has no effect.
- Drop `reset_n` at cycle 10 of a clear → `busy` = 0 immediately, no `clear_done` pulse, all registers read 0. After release, a new `clear_req` completes normally.
